// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// mult_div_unit_pkg : operation and state encodings for the MIPS mult/div unit
// Revision: 1.0
// ============================================================================
package mult_div_unit_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [1:0] MD_IDLE  = 2'b00;
    localparam logic [1:0] MD_CALC  = 2'b01;
    localparam logic [1:0] MD_FIXUP = 2'b10;

    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_if.sv
`default_nettype none
// ============================================================================
// mult_div_unit_if : EX-stage request / HI-LO result bundle of the mult/div unit
// Revision: 1.0
// ============================================================================
interface mult_div_unit_if #(parameter int N = 32);
    logic         start;
    logic [1:0]   op;
    logic [N-1:0] inA;
    logic [N-1:0] inB;
    logic         write_hi;
    logic         write_lo;
    logic [N-1:0] write_data;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;

    modport master (
        output start, op, inA, inB, write_hi, write_lo, write_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, inA, inB, write_hi, write_lo, write_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mult_div_unit_step.sv
`default_nettype none
// ============================================================================
// mult_div_step : one combinational shift-add (mult) or restoring-divide step
// Revision: 1.0
// ============================================================================
module mult_div_step #(
    parameter int N = 32
) (
    input  logic           div_mode,
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   operand,
    output logic [2*N-1:0] acc_next,
    output logic           qbit
);

    logic [N:0]   w_sum;
    logic [N:0]   w_pr;
    logic         w_ge;
    logic [N-1:0] w_rem;

    // Divide view of acc: {partial remainder, remaining dividend bits / quotient}
    always_comb begin
        w_sum    = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, operand} : '0);
        w_pr     = {acc[2*N-1:N], acc[N-1]};
        w_ge     = (w_pr >= {1'b0, operand});
        w_rem    = w_ge ? (w_pr[N-1:0] - operand) : w_pr[N-1:0];
        qbit     = 1'b0;
        acc_next = {w_sum, acc[N-1:1]};
        if (div_mode) begin
            qbit     = w_ge;
            acc_next = {w_rem, acc[N-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : iterative N-cycle mult/multu/div/divu with architectural HI/LO
// Revision: 1.0
// ============================================================================
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic             clock,
    input  logic             reset,
    mult_div_unit_if.slave   md
);
    import mult_div_unit_pkg::*;

    localparam int                 c_cnt_w = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic               r_zero_div;
    logic               r_done;
    logic               r_dbz;
    logic               w_busy;
    logic               w_qbit;
    logic [N-1:0]       r_mag_b;
    logic [N-1:0]       r_hi;
    logic [N-1:0]       r_lo;
    logic [N-1:0]       w_abs_a;
    logic [N-1:0]       w_abs_b;
    logic [N-1:0]       w_quot;
    logic [N-1:0]       w_rem;
    logic [2*N-1:0]     r_acc;
    logic [2*N-1:0]     w_step_acc;
    logic [2*N-1:0]     w_prod;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= MD_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE:  if (md.start) w_state_next = MD_CALC;
            MD_CALC:  if (r_cnt == c_last) w_state_next = MD_FIXUP;
            MD_FIXUP: w_state_next = MD_IDLE;
            default:  w_state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != MD_IDLE);
    end

    mult_div_step #(.N(N)) u_step (
        .div_mode (is_div_op(r_op)),
        .acc      (r_acc),
        .operand  (r_mag_b),
        .acc_next (w_step_acc),
        .qbit     (w_qbit)
    );

    // Sign flags are only ever set for signed ops, so unsigned fixup is a no-op
    always_comb begin
        w_abs_a = (is_signed_op(md.op) && md.inA[N-1]) ? -md.inA : md.inA;
        w_abs_b = (is_signed_op(md.op) && md.inB[N-1]) ? -md.inB : md.inB;
        w_prod  = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
        w_quot  = (r_sign_a ^ r_sign_b) ? -r_acc[N-1:0] : r_acc[N-1:0];
        w_rem   = r_sign_a ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op       <= MD_MULT;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_zero_div <= 1'b0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MD_IDLE: begin
                    if (md.start) begin
                        r_op       <= md.op;
                        r_sign_a   <= is_signed_op(md.op) & md.inA[N-1];
                        r_sign_b   <= is_signed_op(md.op) & md.inB[N-1];
                        r_zero_div <= is_div_op(md.op) & (md.inB == '0);
                        r_mag_b    <= w_abs_b;
                        r_acc      <= {{N{1'b0}}, w_abs_a};
                        r_cnt      <= '0;
                        r_dbz      <= 1'b0;
                    end else begin
                        if (md.write_hi) r_hi <= md.write_data;
                        if (md.write_lo) r_lo <= md.write_data;
                    end
                end
                MD_CALC: begin
                    r_acc <= is_div_op(r_op) ? {w_step_acc[2*N-1:1], w_qbit} : w_step_acc;
                    r_cnt <= r_cnt + 1'b1;
                end
                MD_FIXUP: begin
                    if (is_div_op(r_op)) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*N-1:N];
                        r_lo <= w_prod[N-1:0];
                    end
                    r_done <= 1'b1;
                    r_dbz  <= r_zero_div;
                end
                default: ;
            endcase
        end
    end

    assign md.busy        = w_busy;
    assign md.done        = r_done;
    assign md.div_by_zero = r_dbz;
    assign md.hi          = r_hi;
    assign md.lo          = r_lo;

endmodule
`default_nettype wire
